// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-for-N debounce FSM,
// active-low clean level, press/release strobes and a one-shot long-press strobe.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BUT1,
    output logic BUT_DB,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LCNT_ONE  = LW'(1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        CONF_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        CONF_RELEASE = 2'd3
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] lcnt;

    // Idle level of the pin is 1, so the synchroniser resets to "released".
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= BUT1;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RELEASED;
            dcnt    <= '0;
            lcnt    <= '0;
            BUT_DB  <= 1'b1;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            LONG    <= 1'b0;
        end else begin
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            LONG    <= 1'b0;

            // The long timer runs through release bounces and saturates so LONG fires once.
            if (state == PRESSED || state == CONF_RELEASE) begin
                if (lcnt < LCNT_MAX) begin
                    lcnt <= lcnt + LCNT_ONE;
                    LONG <= (lcnt == LCNT_LAST);
                end
            end

            case (state)
                RELEASED: begin
                    if (!sync2) begin
                        state <= CONF_PRESS;
                        dcnt  <= DCNT_ONE;
                    end else begin
                        dcnt <= '0;
                    end
                end
                CONF_PRESS: begin
                    if (sync2) begin
                        state <= RELEASED;
                        dcnt  <= '0;
                    end else if (dcnt == DCNT_LAST) begin
                        state  <= PRESSED;
                        dcnt   <= '0;
                        lcnt   <= '0;
                        BUT_DB <= 1'b0;
                        PRESS  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DCNT_ONE;
                    end
                end
                PRESSED: begin
                    if (sync2) begin
                        state <= CONF_RELEASE;
                        dcnt  <= DCNT_ONE;
                    end
                end
                CONF_RELEASE: begin
                    if (!sync2) begin
                        state <= PRESSED;
                        dcnt  <= '0;
                    end else if (dcnt == DCNT_LAST) begin
                        state   <= RELEASED;
                        dcnt    <= '0;
                        BUT_DB  <= 1'b1;
                        RELEASE <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DCNT_ONE;
                    end
                end
                default: begin
                    state <= RELEASED;
                    dcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: strobe events are predicted as (cycle, kind)
// words in a queue and matched against what the DUT emits.
module tb_button_debounce;

    localparam int DEB  = 4;
    localparam int LNG  = 10;
    localparam int W    = 32;
    localparam logic [2:0] K_PRESS   = 3'b001;
    localparam logic [2:0] K_RELEASE = 3'b010;
    localparam logic [2:0] K_LONG    = 3'b100;

    logic CLK;
    logic RST;
    logic BUT1;
    logic BUT_DB;
    logic PRESS;
    logic RELEASE;
    logic LONG;

    int total;
    int bad;
    int cyc;
    int n;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;
    logic [W-1:0] want;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LNG)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .BUT1(BUT1),
        .BUT_DB(BUT_DB),
        .PRESS(PRESS),
        .RELEASE(RELEASE),
        .LONG(LONG)
    );

    // Clock and cycle index (number of posedges seen so far)
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input int c, input logic [2:0] k);
        logic [W-4:0] cc;
        cc = c[W-4:0];
        return {cc, k};
    endfunction

    task automatic wait_neg(input int cycles);
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_db"}, BUT_DB, 1'b1);
        check({tag, "_press"}, PRESS, 1'b0);
        check({tag, "_release"}, RELEASE, 1'b0);
        check({tag, "_long"}, LONG, 1'b0);
    endtask

    // Scoreboard: every strobe cycle must match the head of the expected queue.
    always @(negedge CLK) begin
        if (!RST && (PRESS || RELEASE || LONG)) begin
            got = mk(cyc, {LONG, RELEASE, PRESS});
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL unexpected_event: observed cyc=%0d kind=%b expected none",
                       cyc, got[2:0]);
            end else begin
                want = exp_q.pop_front();
                assert (got === want) else begin
                    bad++;
                    $error("FAIL event: observed cyc=%0d kind=%b expected cyc=%0d kind=%b",
                           got[W-1:3], got[2:0], want[W-1:3], want[2:0]);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        BUT1  = 1'b1;

        // Reset acts before any clock edge
        #2;
        check_idle("rst_noclk");
        wait_neg(2);
        RST = 1'b0;
        wait_neg(3);
        check_idle("post_rst");

        // Asynchronous reset mid-cycle with the button idle
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 check_idle("async_rst_idle");
        @(negedge CLK);
        RST = 1'b0;
        wait_neg(2);

        // Clean press held into a long press, then release
        n = cyc;
        BUT1 = 1'b0;
        exp_q.push_back(mk(n + DEB + 2, K_PRESS));
        exp_q.push_back(mk(n + DEB + 2 + LNG, K_LONG));
        wait_neg(DEB + 1);
        check("press_db_before", BUT_DB, 1'b1);
        wait_neg(1);
        check("press_db_after", BUT_DB, 1'b0);
        check("press_strobe", PRESS, 1'b1);
        check("press_no_release", RELEASE, 1'b0);
        wait_neg(1);
        check("press_drop", PRESS, 1'b0);
        wait_neg(LNG - 1);
        check("long_strobe", LONG, 1'b1);
        wait_neg(1);
        check("long_drop", LONG, 1'b0);
        check("long_db_held", BUT_DB, 1'b0);
        wait_neg(15);
        n = cyc;
        BUT1 = 1'b1;
        exp_q.push_back(mk(n + DEB + 2, K_RELEASE));
        wait_neg(DEB + 2);
        check("long_release_strobe", RELEASE, 1'b1);
        check("long_release_db", BUT_DB, 1'b1);
        wait_neg(4);

        // Bouncy press: 0,1,0,0,1,0 then held low, released before LONG falls due
        n = cyc;
        BUT1 = 1'b0; wait_neg(1);
        BUT1 = 1'b1; wait_neg(1);
        BUT1 = 1'b0; wait_neg(1);
        wait_neg(1);
        BUT1 = 1'b1; wait_neg(1);
        BUT1 = 1'b0;
        exp_q.push_back(mk(n + 5 + DEB + 2, K_PRESS));
        wait_neg(DEB + 1);
        check("bounce_db_before", BUT_DB, 1'b1);
        wait_neg(1);
        check("bounce_db_after", BUT_DB, 1'b0);
        wait_neg(3);
        n = cyc;
        BUT1 = 1'b1;
        exp_q.push_back(mk(n + DEB + 2, K_RELEASE));
        wait_neg(10);
        check("bounce_release_db", BUT_DB, 1'b1);

        // Release committing in the same cycle LONG falls due
        n = cyc;
        BUT1 = 1'b0;
        exp_q.push_back(mk(n + DEB + 2, K_PRESS));
        wait_neg(DEB + 2 + LNG - DEB - 2);
        BUT1 = 1'b1;
        exp_q.push_back(mk(n + DEB + 2 + LNG, K_RELEASE | K_LONG));
        wait_neg(DEB + 2);
        check("simul_release", RELEASE, 1'b1);
        check("simul_long", LONG, 1'b1);
        wait_neg(3);

        // Short press: 8 cycles low, LONG must not fire
        n = cyc;
        BUT1 = 1'b0;
        exp_q.push_back(mk(n + DEB + 2, K_PRESS));
        wait_neg(8);
        BUT1 = 1'b1;
        exp_q.push_back(mk(n + 8 + DEB + 2, K_RELEASE));
        wait_neg(12);
        check("short_db", BUT_DB, 1'b1);

        // Reset while pressed: no RELEASE, then a fresh PRESS at full latency
        n = cyc;
        BUT1 = 1'b0;
        exp_q.push_back(mk(n + DEB + 2, K_PRESS));
        wait_neg(8);
        check("pre_rst_db", BUT_DB, 1'b0);
        #2 RST = 1'b1;
        #1 check_idle("mid_press_rst");
        @(negedge CLK);
        n = cyc;
        RST = 1'b0;
        exp_q.push_back(mk(n + DEB + 2, K_PRESS));
        wait_neg(DEB + 1);
        check("repress_db_before", BUT_DB, 1'b1);
        wait_neg(1);
        check("repress_db_after", BUT_DB, 1'b0);
        wait_neg(2);
        n = cyc;
        BUT1 = 1'b1;
        exp_q.push_back(mk(n + DEB + 2, K_RELEASE));
        wait_neg(12);
        check("repress_release_db", BUT_DB, 1'b1);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL pending_events: observed %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
